// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file sequencer: widths, opcodes,
// FSM state encoding and small opcode-class helpers.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_RDO = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    // Only arithmetic/logic ops touch the flags.
    function automatic logic op_sets_flags(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    // NOP and RDO complete without touching the register file.
    function automatic logic op_writes(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_RDO);
    endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bundle of the operation handshake and the register-file port set.
// master: sequencer side; slave: instruction source + register file side.
interface regfile_sequencer_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              flag_z;
    logic              flag_c;

    modport master (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rd1, rd2,
        output in_ready, ra1, ra2, we, wa, wd, done, result, flag_z, flag_c
    );

    modport slave (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rd1, rd2,
        input  in_ready, ra1, ra2, we, wa, wd, done, result, flag_z, flag_c
    );

endinterface

// File: rtl/seq_alu.sv
// Combinational datapath: op_a/op_b/imm -> {carry, result}.
// Ports: i_op, i_a, i_b, i_imm in; o_result, o_carry out.
module seq_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);

    logic [DATA_W:0] w_wide;

    // Top bit of the widened subtract is the borrow (a < b).
    always_comb begin
        w_wide = '0;
        unique case (i_op)
            OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            OP_OR:   w_wide = {1'b0, i_a | i_b};
            OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
            OP_LDI:  w_wide = {1'b0, i_imm};
            OP_RDO:  w_wide = {1'b0, i_a};
            default: w_wide = '0;
        endcase
    end

    assign o_result = w_wide[DATA_W-1:0];
    assign o_carry  = w_wide[DATA_W];

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle read-modify-write sequencer in front of a 4x8 register file.
// Ports: clk, rst (sync, active high), bus (regfile_sequencer_if.master).
module regfile_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    regfile_sequencer_if.master bus
);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_c;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (r_op),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .i_imm    (r_imm),
        .o_result (w_alu_res),
        .o_carry  (w_alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.in_valid) w_next = S_READ;
            S_READ: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_NOP;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op  <= bus.in_op;
                        r_rd  <= bus.in_rd;
                        r_rs1 <= bus.in_rs1;
                        r_rs2 <= bus.in_rs2;
                        r_imm <= bus.in_imm;
                    end
                end
                S_READ: begin
                    r_op_a <= bus.rd1;
                    r_op_b <= bus.rd2;
                end
                S_EXEC: begin
                    // NOP keeps the previous result visible.
                    if (r_op != OP_NOP) r_result <= w_alu_res;
                    if (op_sets_flags(r_op)) begin
                        r_flag_z <= (w_alu_res == '0);
                        r_flag_c <= w_alu_c;
                    end
                end
                S_WB: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (r_state == S_IDLE);
        bus.ra1      = r_rs1;
        bus.ra2      = r_rs2;
        bus.we       = 1'b0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.done     = 1'b0;
        if (r_state == S_WB) begin
            bus.we   = op_writes(r_op);
            bus.wa   = r_rd;
            bus.wd   = r_result;
            bus.done = 1'b1;
        end
        bus.result = r_result;
        bus.flag_z = r_flag_z;
        bus.flag_c = r_flag_c;
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: sequencer driving a behavioural 4x8 register file.
// Ports: none (top-level bench).
module tb_regfile_sequencer;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    logic [7:0] rf [4];

    int n_cmp = 0;
    int n_bad = 0;

    regfile_sequencer_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    regfile_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];

    always @(posedge clk) begin
        if (bus.we) rf[bus.wa] <= bus.wd;
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
        logic       we;
        logic [7:0] res;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs [9];

    int         s_lat;
    bit         s_done;
    bit         s_spur;
    logic       s_we;
    logic [1:0] s_wa;
    logic [7:0] s_wd;
    logic [7:0] s_res;
    logic       s_z;
    logic       s_c;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [7:0] imm);
        @(negedge clk);
        chk("ready_before_issue", int'(bus.in_ready), 1);
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        s_lat  = 0;
        s_done = 1'b0;
        s_spur = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_lat++;
            if (bus.done) begin
                s_done = 1'b1;
                s_we   = bus.we;
                s_wa   = bus.wa;
                s_wd   = bus.wd;
                s_res  = bus.result;
                s_z    = bus.flag_z;
                s_c    = bus.flag_c;
                break;
            end
            if (bus.we) s_spur = 1'b1;
        end
        chk("done_seen", int'(s_done), 1);
    endtask

    task automatic check_op(input string tag, input vec_t v);
        wait_done();
        if (s_done) begin
            chk({tag, "_lat"}, s_lat, 3);
            chk({tag, "_we"}, int'(s_we), int'(v.we));
            chk({tag, "_we_early"}, int'(s_spur), 0);
            if (v.we) begin
                chk({tag, "_wa"}, int'(s_wa), int'(v.rd));
                chk({tag, "_wd"}, int'(s_wd), int'(v.res));
            end
            chk({tag, "_res"}, int'(s_res), int'(v.res));
            chk({tag, "_z"}, int'(s_z), int'(v.z));
            chk({tag, "_c"}, int'(s_c), int'(v.c));
        end
    endtask

    initial begin
        vec_t       v;
        int         low;
        int         dones;
        int         pulses;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;

        //        op      rd    rs1   rs2   imm    we    res    z     c
        vecs[0] = '{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{OP_LDI, 2'd2, 2'd0, 2'd0, 8'hC5, 1'b1, 8'hC5, 1'b0, 1'b0};
        vecs[2] = '{OP_ADD, 2'd3, 2'd1, 2'd2, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[3] = '{OP_RDO, 2'd0, 2'd3, 2'd0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[4] = '{OP_SUB, 2'd0, 2'd1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{OP_SUB, 2'd0, 2'd1, 2'd2, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1};
        vecs[6] = '{OP_XOR, 2'd1, 2'd1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{OP_OR,  2'd3, 2'd2, 2'd0, 8'h00, 1'b1, 8'hF7, 1'b0, 1'b0};
        vecs[8] = '{OP_AND, 2'd0, 2'd3, 2'd2, 8'h00, 1'b1, 8'hC5, 1'b0, 1'b0};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op    = OP_NOP;
        bus.in_rd    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_imm   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(bus.in_ready), 1);
        chk("rst_we", int'(bus.we), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_z", int'(bus.flag_z), 0);
        chk("rst_c", int'(bus.flag_c), 0);
        chk("rst_wa", int'(bus.wa), 0);
        chk("rst_wd", int'(bus.wd), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            issue(v.op, v.rd, v.rs1, v.rs2, v.imm);
            check_op($sformatf("vec%0d", i), v);
        end
        chk("rf1_after_xor", int'(rf[1]), 8'h00);

        // Back-to-back: valid held high; second op reads the first's write.
        @(negedge clk);
        chk("b2b_ready0", int'(bus.in_ready), 1);
        bus.in_op    = OP_LDI;
        bus.in_rd    = 2'd1;
        bus.in_imm   = 8'h80;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_op  = OP_ADD;
        bus.in_rd  = 2'd1;
        bus.in_rs1 = 2'd1;
        bus.in_rs2 = 2'd1;
        low   = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            low++;
            if (bus.done) dones++;
        end
        chk("b2b_ready_low", low, 3);
        chk("b2b_dones", dones, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        v = '{OP_ADD, 2'd1, 2'd1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
        check_op("b2b_add", v);

        // Reset during EXEC abandons the write.
        issue(OP_ADD, 2'd2, 2'd0, 2'd3, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", int'(bus.in_ready), 1);
        chk("mid_rst_result", int'(bus.result), 0);
        chk("mid_rst_z", int'(bus.flag_z), 0);
        chk("mid_rst_c", int'(bus.flag_c), 0);
        for (int i = 0; i < 4; i++) begin
            if (bus.we || bus.done) pulses++;
            @(negedge clk);
        end
        chk("mid_rst_pulses", pulses, 0);
        chk("mid_rst_rf2", int'(rf[2]), 8'hC5);
        v = '{OP_RDO, 2'd0, 2'd2, 2'd0, 8'h00, 1'b0, 8'hC5, 1'b0, 1'b0};
        issue(v.op, v.rd, v.rs1, v.rs2, v.imm);
        check_op("rdo_rf2", v);

        // NOP keeps result and flags from the preceding ADD.
        v = '{OP_ADD, 2'd3, 2'd2, 2'd2, 8'h00, 1'b1, 8'h8A, 1'b0, 1'b1};
        issue(v.op, v.rd, v.rs1, v.rs2, v.imm);
        check_op("add_pre_nop", v);
        v = '{OP_NOP, 2'd2, 2'd0, 2'd0, 8'h55, 1'b0, 8'h8A, 1'b0, 1'b1};
        issue(v.op, v.rd, v.rs1, v.rs2, v.imm);
        check_op("nop", v);
        chk("nop_rf2", int'(rf[2]), 8'hC5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
